// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipelined control unit: opcodes, ALU and branch
// codes, halt FSM states and the control bundle carried down the pipe.
package pipe_ctrl_pkg;

   localparam logic [3:0] OP_ADD    = 4'h0;
   localparam logic [3:0] OP_SUB    = 4'h1;
   localparam logic [3:0] OP_XOR    = 4'h2;
   localparam logic [3:0] OP_RED    = 4'h3;
   localparam logic [3:0] OP_SLL    = 4'h4;
   localparam logic [3:0] OP_SRA    = 4'h5;
   localparam logic [3:0] OP_ROR    = 4'h6;
   localparam logic [3:0] OP_PADDSB = 4'h7;
   localparam logic [3:0] OP_LW     = 4'h8;
   localparam logic [3:0] OP_SW     = 4'h9;
   localparam logic [3:0] OP_LLB    = 4'hA;
   localparam logic [3:0] OP_LHB    = 4'hB;
   localparam logic [3:0] OP_B      = 4'hC;
   localparam logic [3:0] OP_BR     = 4'hD;
   localparam logic [3:0] OP_PCS    = 4'hE;
   localparam logic [3:0] OP_HLT    = 4'hF;

   localparam logic [3:0] ALU_ADD    = 4'd0;
   localparam logic [3:0] ALU_SUB    = 4'd1;
   localparam logic [3:0] ALU_XOR    = 4'd2;
   localparam logic [3:0] ALU_RED    = 4'd3;
   localparam logic [3:0] ALU_SLL    = 4'd4;
   localparam logic [3:0] ALU_SRA    = 4'd5;
   localparam logic [3:0] ALU_ROR    = 4'd6;
   localparam logic [3:0] ALU_PADDSB = 4'd7;
   localparam logic [3:0] ALU_LLB    = 4'd8;
   localparam logic [3:0] ALU_LHB    = 4'd9;

   localparam logic [1:0] BR_PC2   = 2'd0;
   localparam logic [1:0] BR_PCIMM = 2'd1;
   localparam logic [1:0] BR_REG   = 2'd2;
   localparam logic [1:0] BR_HALT  = 2'd3;

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_e;

   // An all-zero bundle is a bubble.
   typedef struct packed {
      logic       valid;
      logic       regwrite;
      logic       alusrc;
      logic       alusext;
      logic       pcread;
      logic       memread;
      logic       memwrite;
      logic       memtoreg;
      logic [3:0] aluop;
      logic [1:0] branch;
   } ctrl_t;

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational opcode decode: control bundle plus which register sources
// the instruction actually reads (used by the load-use hazard check).
module pipe_ctrl_decode
   import pipe_ctrl_pkg::*;
(
   input  logic [3:0] opcode,
   output ctrl_t      ctrl,
   output logic       src1_is_rd,
   output logic       use_src1,
   output logic       use_src2
);

   // Table decode; every field gets a default so unused opcodes decode to zeros.
   always_comb begin
      ctrl        = '0;
      ctrl.valid  = 1'b1;
      ctrl.aluop  = ALU_ADD;
      ctrl.branch = BR_PC2;
      src1_is_rd  = 1'b0;
      use_src1    = 1'b0;
      use_src2    = 1'b0;
      case (opcode)
         OP_ADD:    begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_ADD;    use_src1 = 1'b1; use_src2 = 1'b1; end
         OP_SUB:    begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_SUB;    use_src1 = 1'b1; use_src2 = 1'b1; end
         OP_XOR:    begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_XOR;    use_src1 = 1'b1; use_src2 = 1'b1; end
         OP_RED:    begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_RED;    use_src1 = 1'b1; use_src2 = 1'b1; end
         OP_SLL:    begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_SLL; use_src1 = 1'b1; end
         OP_SRA:    begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_SRA; use_src1 = 1'b1; end
         OP_ROR:    begin ctrl.regwrite = 1'b1; ctrl.alusrc = 1'b1; ctrl.aluop = ALU_ROR; use_src1 = 1'b1; end
         OP_PADDSB: begin ctrl.regwrite = 1'b1; ctrl.aluop = ALU_PADDSB; use_src1 = 1'b1; use_src2 = 1'b1; end
         OP_LW: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.memread  = 1'b1;
            ctrl.memtoreg = 1'b1;
            ctrl.aluop    = ALU_ADD;
            use_src1      = 1'b1;
         end
         OP_SW: begin
            ctrl.alusrc   = 1'b1;
            ctrl.memwrite = 1'b1;
            ctrl.aluop    = ALU_ADD;
            use_src1      = 1'b1;
            use_src2      = 1'b1;
         end
         OP_LLB: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.alusext  = 1'b1;
            ctrl.aluop    = ALU_LLB;
            src1_is_rd    = 1'b1;
            use_src1      = 1'b1;
         end
         OP_LHB: begin
            ctrl.regwrite = 1'b1;
            ctrl.alusrc   = 1'b1;
            ctrl.alusext  = 1'b1;
            ctrl.aluop    = ALU_LHB;
            src1_is_rd    = 1'b1;
            use_src1      = 1'b1;
         end
         OP_B:   begin ctrl.branch = BR_PCIMM; end
         OP_BR:  begin ctrl.branch = BR_REG; use_src1 = 1'b1; end
         OP_PCS: begin ctrl.regwrite = 1'b1; ctrl.pcread = 1'b1; end
         OP_HLT: begin ctrl.branch = BR_HALT; end
         default: begin ctrl.branch = BR_PC2; end
      endcase
   end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipelined control unit: decodes ID, carries the bundle through EX/MEM/WB,
// handles load-use stalls, branch flushes, memory freezes and halt draining.
module pipe_ctrl
   import pipe_ctrl_pkg::*;
#(
   parameter int RIDX_W       = 4,
   parameter int DRAIN_CYCLES = 3,
   parameter int R0_HARDWIRED = 1
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              id_valid,
   input  logic [3:0]        id_opcode,
   input  logic [RIDX_W-1:0] id_rs,
   input  logic [RIDX_W-1:0] id_rt,
   input  logic [RIDX_W-1:0] id_rd,
   input  logic              ex_flush,
   input  logic              mem_stall,
   output logic              stall_if,
   output logic              ex_valid,
   output logic              ex_regwrite,
   output logic              ex_alusrc,
   output logic              ex_alusext,
   output logic              ex_pcread,
   output logic [3:0]        ex_aluop,
   output logic [1:0]        ex_branch,
   output logic [RIDX_W-1:0] ex_rd,
   output logic              mem_valid,
   output logic              mem_memread,
   output logic              mem_memwrite,
   output logic              mem_memtoreg,
   output logic              mem_regwrite,
   output logic [RIDX_W-1:0] mem_rd,
   output logic              wb_valid,
   output logic              wb_regwrite,
   output logic              wb_memtoreg,
   output logic [RIDX_W-1:0] wb_rd,
   output logic              halted
);

   localparam int               CNT_W    = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DRAIN_CYCLES - 1);

   ctrl_t             dec_ctrl;
   ctrl_t             id_ctrl;
   ctrl_t             ex_ctrl;
   logic              src1_is_rd;
   logic              use_src1;
   logic              use_src2;
   logic [RIDX_W-1:0] src1;
   logic              src1_hit;
   logic              src2_hit;
   logic              load_use;
   logic              id_advance;
   logic              halt_go;
   logic              drain_done;
   logic [CNT_W-1:0]  drain_cnt;
   state_e            state;
   state_e            state_next;

   pipe_ctrl_decode u_decode (
      .opcode     (id_opcode),
      .ctrl       (dec_ctrl),
      .src1_is_rd (src1_is_rd),
      .use_src1   (use_src1),
      .use_src2   (use_src2)
   );

   // A source only conflicts with a pending load when it is actually read;
   // register 0 optionally never conflicts since it cannot be written.
   assign src1     = src1_is_rd ? id_rd : id_rs;
   assign src1_hit = use_src1 && (src1 == ex_rd) && !((R0_HARDWIRED != 0) && (src1 == '0));
   assign src2_hit = use_src2 && (id_rt == ex_rd) && !((R0_HARDWIRED != 0) && (id_rt == '0));
   assign load_use = id_valid && ex_ctrl.valid && ex_ctrl.memread && (src1_hit || src2_hit);

   // The ID instruction enters EX only in RUN with nothing stalling or killing it.
   assign id_advance = (state == ST_RUN) && !mem_stall && !ex_flush && !load_use && id_valid;
   assign id_ctrl    = id_advance ? dec_ctrl : '0;
   assign halt_go    = id_advance && (id_opcode == OP_HLT);
   assign drain_done = (drain_cnt == CNT_LAST);

   assign ex_valid    = ex_ctrl.valid;
   assign ex_regwrite = ex_ctrl.regwrite;
   assign ex_alusrc   = ex_ctrl.alusrc;
   assign ex_alusext  = ex_ctrl.alusext;
   assign ex_pcread   = ex_ctrl.pcread;
   assign ex_aluop    = ex_ctrl.aluop;
   assign ex_branch   = ex_ctrl.branch;

   // Halt FSM state register; a memory freeze holds the state.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_RUN;
      end else begin
         state <= state_next;
      end
   end

   // Halt FSM transitions: a committed HLT starts the drain, the drain counter ends it.
   always_comb begin
      state_next = state;
      if (!mem_stall) begin
         case (state)
            ST_RUN:    if (halt_go) state_next = ST_DRAIN;
            ST_DRAIN:  if (drain_done) state_next = ST_HALTED;
            ST_HALTED: state_next = ST_HALTED;
            default:   state_next = ST_RUN;
         endcase
      end
   end

   // FSM outputs: hold fetch on freeze, load-use (unless flushed) or any non-RUN state.
   always_comb begin
      stall_if = 1'b0;
      halted   = (state == ST_HALTED);
      if (!rst) begin
         stall_if = mem_stall || (state != ST_RUN) || (load_use && !ex_flush);
      end
   end

   // Drain counter counts only unfrozen cycles spent in DRAIN.
   always_ff @(posedge clk) begin
      if (rst) begin
         drain_cnt <= '0;
      end else if (!mem_stall) begin
         if (state == ST_DRAIN) begin
            drain_cnt <= drain_cnt + 1'b1;
         end else begin
            drain_cnt <= '0;
         end
      end
   end

   // Stage registers EX/MEM/WB advance together unless memory freezes the pipe.
   always_ff @(posedge clk) begin
      if (rst) begin
         ex_ctrl      <= '0;
         ex_rd        <= '0;
         mem_valid    <= 1'b0;
         mem_memread  <= 1'b0;
         mem_memwrite <= 1'b0;
         mem_memtoreg <= 1'b0;
         mem_regwrite <= 1'b0;
         mem_rd       <= '0;
         wb_valid     <= 1'b0;
         wb_regwrite  <= 1'b0;
         wb_memtoreg  <= 1'b0;
         wb_rd        <= '0;
      end else if (!mem_stall) begin
         ex_ctrl      <= id_ctrl;
         ex_rd        <= id_advance ? id_rd : '0;
         mem_valid    <= ex_ctrl.valid;
         mem_memread  <= ex_ctrl.memread;
         mem_memwrite <= ex_ctrl.memwrite;
         mem_memtoreg <= ex_ctrl.memtoreg;
         mem_regwrite <= ex_ctrl.regwrite;
         mem_rd       <= ex_rd;
         wb_valid     <= mem_valid;
         wb_regwrite  <= mem_regwrite;
         wb_memtoreg  <= mem_memtoreg;
         wb_rd        <= mem_rd;
      end
   end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Testbench for pipe_ctrl: directed scenarios then random traffic, all
// compared every cycle against a stage-queue reference model.
module tb_pipe_ctrl;

   localparam int RIDX_W       = 4;
   localparam int DRAIN_CYCLES = 3;

   // Opcode property masks, one bit per opcode.
   localparam int RW_MASK   = 32'h4DFF;
   localparam int SRC_MASK  = 32'h0F70;
   localparam int USE1_MASK = 32'h2FFF;
   localparam int USE2_MASK = 32'h028F;

   logic              clk = 1'b0;
   logic              rst;
   logic              id_valid;
   logic [3:0]        id_opcode;
   logic [RIDX_W-1:0] id_rs, id_rt, id_rd;
   logic              ex_flush, mem_stall;
   logic              stall_if;
   logic              ex_valid, ex_regwrite, ex_alusrc, ex_alusext, ex_pcread;
   logic [3:0]        ex_aluop;
   logic [1:0]        ex_branch;
   logic [RIDX_W-1:0] ex_rd;
   logic              mem_valid, mem_memread, mem_memwrite, mem_memtoreg, mem_regwrite;
   logic [RIDX_W-1:0] mem_rd;
   logic              wb_valid, wb_regwrite, wb_memtoreg;
   logic [RIDX_W-1:0] wb_rd;
   logic              halted;

   typedef struct {
      bit valid;
      int op;
      int rd;
   } slot_t;

   slot_t mEx, mMem, mWb;
   int    mMode;
   int    mLeft;
   int    vectors = 0;
   int    miscompares = 0;
   bit    sampledHalted;

   always #5 clk = ~clk;

   pipe_ctrl #(.RIDX_W(RIDX_W), .DRAIN_CYCLES(DRAIN_CYCLES), .R0_HARDWIRED(1)) dut (
      .clk(clk), .rst(rst), .id_valid(id_valid), .id_opcode(id_opcode),
      .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_flush(ex_flush), .mem_stall(mem_stall),
      .stall_if(stall_if), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite), .ex_alusrc(ex_alusrc),
      .ex_alusext(ex_alusext), .ex_pcread(ex_pcread), .ex_aluop(ex_aluop), .ex_branch(ex_branch),
      .ex_rd(ex_rd), .mem_valid(mem_valid), .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
      .mem_memtoreg(mem_memtoreg), .mem_regwrite(mem_regwrite), .mem_rd(mem_rd),
      .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_memtoreg(wb_memtoreg), .wb_rd(wb_rd),
      .halted(halted)
   );

   function automatic int bitOf(int mask, int op);
      return (mask >> op) & 1;
   endfunction

   function automatic int expAluop(int op);
      if (op >= 1 && op <= 7) return op;
      if (op == 10) return 8;
      if (op == 11) return 9;
      return 0;
   endfunction

   function automatic int expBranch(int op);
      if (op == 12) return 1;
      if (op == 13) return 2;
      if (op == 15) return 3;
      return 0;
   endfunction

   function automatic bit modelLoadUse(bit idv, int op, int rs, int rt, int rd);
      int s1;
      bit hit;
      if (!idv || !mEx.valid || mEx.op != 8) return 1'b0;
      s1  = (op == 10 || op == 11) ? rd : rs;
      hit = 1'b0;
      if (bitOf(USE1_MASK, op) != 0 && s1 != 0 && s1 == mEx.rd) hit = 1'b1;
      if (bitOf(USE2_MASK, op) != 0 && rt != 0 && rt == mEx.rd) hit = 1'b1;
      return hit;
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      vectors++;
      assert (observed === expected)
      else begin
         miscompares++;
         $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
      end
   endtask

   task automatic checkAll(input bit r, input bit mstall, input bit flush, input bit lu);
      bit v;
      v = mEx.valid;
      checkOutput("ex_valid",    32'(ex_valid),    32'(v));
      checkOutput("ex_regwrite", 32'(ex_regwrite), v ? bitOf(RW_MASK, mEx.op) : 0);
      checkOutput("ex_alusrc",   32'(ex_alusrc),   v ? bitOf(SRC_MASK, mEx.op) : 0);
      checkOutput("ex_alusext",  32'(ex_alusext),  32'(v && (mEx.op == 10 || mEx.op == 11)));
      checkOutput("ex_pcread",   32'(ex_pcread),   32'(v && mEx.op == 14));
      checkOutput("ex_aluop",    32'(ex_aluop),    v ? expAluop(mEx.op) : 0);
      checkOutput("ex_branch",   32'(ex_branch),   v ? expBranch(mEx.op) : 0);
      checkOutput("ex_rd",       32'(ex_rd),       mEx.rd);
      v = mMem.valid;
      checkOutput("mem_valid",    32'(mem_valid),    32'(v));
      checkOutput("mem_memread",  32'(mem_memread),  32'(v && mMem.op == 8));
      checkOutput("mem_memwrite", 32'(mem_memwrite), 32'(v && mMem.op == 9));
      checkOutput("mem_memtoreg", 32'(mem_memtoreg), 32'(v && mMem.op == 8));
      checkOutput("mem_regwrite", 32'(mem_regwrite), v ? bitOf(RW_MASK, mMem.op) : 0);
      checkOutput("mem_rd",       32'(mem_rd),       mMem.rd);
      v = mWb.valid;
      checkOutput("wb_valid",    32'(wb_valid),    32'(v));
      checkOutput("wb_regwrite", 32'(wb_regwrite), v ? bitOf(RW_MASK, mWb.op) : 0);
      checkOutput("wb_memtoreg", 32'(wb_memtoreg), 32'(v && mWb.op == 8));
      checkOutput("wb_rd",       32'(wb_rd),       mWb.rd);
      checkOutput("halted",      32'(halted),      32'(mMode == 2));
      checkOutput("stall_if",    32'(stall_if),    32'(!r && (mstall || mMode != 0 || (lu && !flush))));
   endtask

   task automatic modelUpdate(input bit r, input bit idv, input int op, input int rd,
                              input bit flush, input bit mstall, input bit lu);
      int oldMode;
      if (r) begin
         mEx = '{1'b0, 0, 0}; mMem = '{1'b0, 0, 0}; mWb = '{1'b0, 0, 0};
         mMode = 0; mLeft = 0;
      end else if (!mstall) begin
         mWb  = mMem;
         mMem = mEx;
         oldMode = mMode;
         if (oldMode == 1) begin
            mLeft--;
            if (mLeft == 0) mMode = 2;
         end
         if (oldMode == 0 && idv && !flush && !lu) begin
            mEx = '{1'b1, op, rd};
            if (op == 15) begin
               mMode = 1;
               mLeft = DRAIN_CYCLES;
            end
         end else begin
            mEx = '{1'b0, 0, 0};
         end
      end
   endtask

   // One clock: drive at the falling edge, check before the rising edge, then step the model.
   task automatic applyStimulus(input bit r, input bit idv, input int op, input int rs, input int rt,
                                input int rd, input bit flush, input bit mstall);
      bit lu;
      @(negedge clk);
      rst = r; id_valid = idv; id_opcode = 4'(op);
      id_rs = RIDX_W'(rs); id_rt = RIDX_W'(rt); id_rd = RIDX_W'(rd);
      ex_flush = flush; mem_stall = mstall;
      #1;
      lu = modelLoadUse(idv, op, rs, rt, rd);
      checkAll(r, mstall, flush, lu);
      sampledHalted = halted;
      @(posedge clk);
      modelUpdate(r, idv, op, rd, flush, mstall, lu);
   endtask

   task automatic nop(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
   endtask

   // Issue HLT, optionally freeze cycles stallFrom..stallTo, and measure cycles until halted.
   task automatic measureHalt(input int stallFrom, input int stallTo, input int expected, input string tag);
      int lat;
      lat = 0;
      applyStimulus(1'b0, 1'b1, 15, 0, 0, 0, 1'b0, 1'b0);
      for (int i = 1; i <= 20 && lat == 0; i++) begin
         applyStimulus(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, (i >= stallFrom && i <= stallTo));
         if (sampledHalted) lat = i;
      end
      checkOutput(tag, lat, expected);
   endtask

   initial begin
      rst = 1'b1; id_valid = 1'b0; id_opcode = '0; id_rs = '0; id_rt = '0; id_rd = '0;
      ex_flush = 1'b0; mem_stall = 1'b0;
      repeat (2) @(posedge clk);
      modelUpdate(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 1'b0);

      $display("[TB] reset state");
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      nop(1);

      $display("[TB] ADD then SUB back to back");
      applyStimulus(1'b0, 1'b1, 0, 1, 2, 5, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 1, 1, 2, 6, 1'b0, 1'b0);
      nop(4);

      $display("[TB] load-use on r3, then on r0");
      applyStimulus(1'b0, 1'b1, 8, 1, 0, 3, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 0, 3, 4, 7, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 0, 3, 4, 7, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 8, 1, 0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 0, 0, 0, 7, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 11, 0, 0, 3, 1'b0, 1'b0);
      nop(4);

      $display("[TB] branch flush kills XOR");
      applyStimulus(1'b0, 1'b1, 12, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 2, 1, 2, 9, 1'b1, 1'b0);
      nop(4);

      $display("[TB] flushed HLT, then real HLT");
      applyStimulus(1'b0, 1'b1, 15, 0, 0, 0, 1'b1, 1'b0);
      nop(5);
      checkOutput("hltFlushedNotHalted", 32'(sampledHalted), 0);
      measureHalt(0, -1, DRAIN_CYCLES + 1, "haltLatency");
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);

      $display("[TB] memory freeze with LW in MEM");
      applyStimulus(1'b0, 1'b1, 8, 2, 0, 4, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 9, 1, 5, 0, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 14, 0, 0, 6, 1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1, 14, 0, 0, 6, 1'b0, 1'b0);
      nop(4);
      measureHalt(2, 5, DRAIN_CYCLES + 5, "haltLatencyFrozen");

      $display("[TB] reset during DRAIN and HALTED");
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b1, 15, 0, 0, 0, 1'b0, 1'b0);
      nop(1);
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      nop(2);
      applyStimulus(1'b0, 1'b1, 15, 0, 0, 0, 1'b0, 1'b0);
      nop(6);
      applyStimulus(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
      nop(2);

      $display("[TB] random traffic");
      for (int c = 0; c < 600; c++) begin
         int op;
         bit r;
         op = int'($urandom_range(0, 15));
         if (op == 15 && $urandom_range(0, 5) != 0) op = int'($urandom_range(0, 14));
         r = ($urandom_range(0, 63) == 0) || (mMode == 2 && $urandom_range(0, 7) == 0);
         applyStimulus(r, $urandom_range(0, 3) != 0, op,
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                       $urandom_range(0, 9) == 0, $urandom_range(0, 7) == 0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
